// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_ctrl
// Description : Sequential shift-add unsigned multiplier, one bit per cycle,
//               with IDLE/RUN/DONE control and a single shared ripple adder.
// Revision    : 1.0  initial release
// ============================================================================
module seq_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_p;
    logic [WIDTH-1:0]     r_q;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH:0]       w_carry;
    logic                 w_c_add;
    logic [WIDTH-1:0]     w_p_add;
    logic [WIDTH-1:0]     w_p_shift;
    logic [WIDTH-1:0]     w_q_shift;

    // Shared P + M ripple chain: half adder at bit 0, full adders above.
    assign w_carry[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_adder
            if (gi == 0) begin : g_ha
                assign w_sum[gi]       = r_p[gi] ^ r_m[gi];
                assign w_carry[gi + 1] = r_p[gi] & r_m[gi];
            end else begin : g_fa
                assign w_sum[gi]       = r_p[gi] ^ r_m[gi] ^ w_carry[gi];
                assign w_carry[gi + 1] = (r_p[gi] & r_m[gi]) |
                                         (w_carry[gi] & (r_p[gi] ^ r_m[gi]));
            end
        end
    endgenerate

    assign w_c_add   = r_q[0] & w_carry[WIDTH];
    assign w_p_add   = r_q[0] ? w_sum : r_p;
    assign w_p_shift = {w_c_add, w_p_add[WIDTH-1:1]};
    assign w_q_shift = {w_p_add[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_m       <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= a;
                        r_q     <= b;
                        r_p     <= '0;
                        r_count <= '0;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_p <= w_p_shift;
                    r_q <= w_q_shift;
                    // Count saturates at the last iteration instead of wrapping.
                    if (r_count == c_last) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= {w_p_shift, w_q_shift};
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_ctrl
// Description : Scoreboard bench for seq_mult_ctrl (WIDTH=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_mult_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    exp_t           sb[$];
    logic [2*W-1:0] model_prod = '0;
    int             cyc = 0;
    int             n_tests = 0;
    int             n_fail = 0;
    int             n_done = 0;

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: each expected result carries the cycle its done pulse is due.
    always @(negedge clk) begin
        if (done) n_done++;
        if (rst) begin
            sb.delete();
            model_prod = '0;
        end else if (sb.size() > 0 && cyc == sb[0].cyc) begin
            check("done_pulse", done, 1);
            check("product", product, sb[0].prod);
            model_prod = sb[0].prod;
            void'(sb.pop_front());
        end else if (done) begin
            check("spurious_done", done, 0);
        end
    end

    // Issues one operation and returns at the negedge of its DONE cycle with
    // start still high, so the caller may chain another or drop start.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.cyc  = cyc + W;
        sb.push_back(e);
        repeat (W) begin
            @(negedge clk);
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("hold_run", product, model_prod);
            a = W'($urandom);
            b = W'($urandom);
        end
        @(negedge clk);
        check("busy_done", busy, 0);
    endtask

    initial begin
        int done_before;
        logic [7:0] iv;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        rst = 1'b0;

        issue(4'd15, 4'd15);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_hold", product, 8'hE1);

        issue(4'd9, 4'd6);
        start = 1'b0;
        repeat (2) @(negedge clk);
        issue(4'd0, 4'd13);
        start = 1'b0;
        repeat (2) @(negedge clk);

        issue(4'd3, 4'd5);
        issue(4'd7, 4'd7);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_hold2", product, 8'd49);

        // Reset during the second RUN cycle of 12*11.
        a = 4'd12;
        b = 4'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        @(negedge clk);
        rst = 1'b0;
        issue(4'd5, 4'd5);
        start = 1'b0;
        repeat (2) @(negedge clk);

        done_before = n_done;
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            issue(iv[7:4], iv[3:0]);
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);
        check("sweep_done_count", n_done - done_before, 256);
        check("pending_results", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
